// File: rtl/tx_pkg.sv
// tx_pkg: state encoding, byte-request codes and default sync word shared by
// the sample framer and its FIFO.
package tx_pkg;

    // Width of one acquisition sample / transmitted word
    localparam int SAMPLE_W = 16;

    // Framer sequencing states; one word is sent as a high byte then a low byte
    typedef enum logic [1:0] {
        S_Idle  = 2'd0,
        S_ReqHi = 2'd1,
        S_ReqLo = 2'd2
    } state_t;

    // RequestToSend codes seen by the UART transmit wrapper
    localparam logic [1:0] RTS_NONE = 2'b00;
    localparam logic [1:0] RTS_HI   = 2'b10;
    localparam logic [1:0] RTS_LO   = 2'b01;

    // Marker word placed at the head of every frame when headers are enabled
    localparam logic [SAMPLE_W-1:0] SYNC_WORD_DEFAULT = 16'hA55A;

endpackage

// File: rtl/sync_fifo_16.sv
// sync_fifo_16: single-clock FIFO of 16-bit words with a registered full flag.
// The head word is presented combinationally on dout so the consumer can load
// it on the same edge that pops it. A write that arrives while full is still
// accepted when a pop happens on the same edge, since the pop frees the slot.
module sync_fifo_16
    import tx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                wr,
    input  logic [SAMPLE_W-1:0] din,
    input  logic                rd,
    output logic [SAMPLE_W-1:0] dout,
    output logic [AW:0]         count,
    output logic                full
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wrPtr;
    logic [AW-1:0]       rdPtr;
    logic                doWrite;
    logic                doRead;
    logic [AW:0]         nextCount;

    assign doRead  = rd && (count != '0);
    assign doWrite = wr && (!full || doRead);
    assign dout    = mem[rdPtr];

    // Occupancy after this edge; a simultaneous write and read cancel out
    always_comb begin
        nextCount = count;
        case ({doWrite, doRead})
            2'b10:   nextCount = count + 1'b1;
            2'b01:   nextCount = count - 1'b1;
            default: nextCount = count;
        endcase
    end

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge Clock) begin
        if (doWrite) begin
            mem[wrPtr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is 2**AW
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doRead) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= nextCount;
            full  <= (nextCount == FULL_COUNT);
        end
    end

endmodule

// File: rtl/tx_sample_framer.sv
// tx_sample_framer: buffers 16-bit samples and hands them to the UART transmit
// wrapper one byte at a time, high byte first, advancing only on the matching
// DataReceived acknowledge. RequestToSend always changes on the edge that
// samples the matching acknowledge, so the wrapper never latches a byte twice.
//
// Build option TX_SAMPLE_FRAMER_HEADER_EN: when defined, a SYNC_WORD header is
// sent before every FRAME_LEN samples, and the FRAME_LEN / SYNC_WORD parameters
// exist. When undefined, there is no header logic and no frame counter.
module tx_sample_framer
    import tx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
`ifdef TX_SAMPLE_FRAMER_HEADER_EN
    ,
    parameter int                  FRAME_LEN = 64,
    parameter logic [SAMPLE_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT
`endif
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                SampleValid,
    input  logic [SAMPLE_W-1:0] SampleData,
    output logic                Full,
    output logic                Overflow,
    input  logic                ClearOverflow,
    output logic [AW:0]         Count,
    output logic [SAMPLE_W-1:0] Data,
    output logic [1:0]          RequestToSend,
    input  logic [1:0]          DataReceived,
    output logic                Busy
);

    state_t              state;
    logic [SAMPLE_W-1:0] headWord;
    logic [AW:0]         fifoCount;
    logic                fifoFull;
    logic                leaveIdle;
    logic                pop;
    logic                dropWord;

`ifdef TX_SAMPLE_FRAMER_HEADER_EN
    logic [15:0] frameCnt;
    logic        headerSent;
    logic        headerDue;

    // A header is owed at the start of a frame until it has been sent once
    assign headerDue = (frameCnt == 16'd0) && !headerSent;
`endif

    assign leaveIdle = (state == S_Idle) && (fifoCount != '0);

`ifdef TX_SAMPLE_FRAMER_HEADER_EN
    assign pop = leaveIdle && !headerDue;
`else
    assign pop = leaveIdle;
`endif

    // A word is lost only when the FIFO is full and no pop frees a slot
    assign dropWord = SampleValid && fifoFull && !pop;

    assign Full  = fifoFull;
    assign Count = fifoCount;
    assign Busy  = (state != S_Idle) || (fifoCount != '0);

    sync_fifo_16 #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) fifo (
        .Clock (Clock),
        .Reset (Reset),
        .wr    (SampleValid),
        .din   (SampleData),
        .rd    (pop),
        .dout  (headWord),
        .count (fifoCount),
        .full  (fifoFull)
    );

    // Sticky overflow flag; a new drop outranks a clear in the same cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Overflow <= 1'b0;
        end else if (dropWord) begin
            Overflow <= 1'b1;
        end else if (ClearOverflow) begin
            Overflow <= 1'b0;
        end
    end

`ifdef TX_SAMPLE_FRAMER_HEADER_EN
    // Frame bookkeeping: note a sent header, then count popped samples per frame
    always_ff @(posedge Clock) begin
        if (Reset) begin
            frameCnt   <= 16'd0;
            headerSent <= 1'b0;
        end else if (leaveIdle) begin
            if (headerDue) begin
                headerSent <= 1'b1;
            end else begin
                headerSent <= 1'b0;
                if (frameCnt == 16'(FRAME_LEN - 1)) begin
                    frameCnt <= 16'd0;
                end else begin
                    frameCnt <= frameCnt + 16'd1;
                end
            end
        end
    end
`endif

    // Byte sequencer: load a word on leaving idle, then step hi -> lo -> idle on acks
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= S_Idle;
            RequestToSend <= RTS_NONE;
            Data          <= '0;
        end else begin
            case (state)
                S_Idle: begin
                    if (fifoCount != '0) begin
`ifdef TX_SAMPLE_FRAMER_HEADER_EN
                        Data <= headerDue ? SYNC_WORD : headWord;
`else
                        Data <= headWord;
`endif
                        RequestToSend <= RTS_HI;
                        state         <= S_ReqHi;
                    end else begin
                        RequestToSend <= RTS_NONE;
                    end
                end
                S_ReqHi: begin
                    if (DataReceived[1]) begin
                        RequestToSend <= RTS_LO;
                        state         <= S_ReqLo;
                    end
                end
                S_ReqLo: begin
                    if (DataReceived[0]) begin
                        RequestToSend <= RTS_NONE;
                        state         <= S_Idle;
                    end
                end
                default: begin
                    RequestToSend <= RTS_NONE;
                    state         <= S_Idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_sample_framer.sv
// tb_tx_sample_framer: self-checking bench for tx_sample_framer. Expected words
// come from a queue model of the transmitted stream; timing expectations come
// from the documented latency rules.
module tb_tx_sample_framer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef TX_SAMPLE_FRAMER_HEADER_EN
    localparam int          FRAME_LEN = 2;
    localparam logic [15:0] SYNC      = 16'hA55A;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic        SampleValid;
    logic [15:0] SampleData;
    logic        Full;
    logic        Overflow;
    logic        ClearOverflow;
    logic [AW:0] Count;
    logic [15:0] Data;
    logic [1:0]  RequestToSend;
    logic [1:0]  DataReceived;
    logic        Busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] expQ[$];
    int          sampleIdx = 0;

    tx_sample_framer #(
        .DEPTH (DEPTH),
        .AW    (AW)
`ifdef TX_SAMPLE_FRAMER_HEADER_EN
        ,
        .FRAME_LEN (FRAME_LEN),
        .SYNC_WORD (SYNC)
`endif
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .SampleValid   (SampleValid),
        .SampleData    (SampleData),
        .Full          (Full),
        .Overflow      (Overflow),
        .ClearOverflow (ClearOverflow),
        .Count         (Count),
        .Data          (Data),
        .RequestToSend (RequestToSend),
        .DataReceived  (DataReceived),
        .Busy          (Busy)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Transmitted-stream model: a header precedes every FRAME_LEN-th sample
    task automatic pushSample(input logic [15:0] w);
`ifdef TX_SAMPLE_FRAMER_HEADER_EN
        if (sampleIdx % FRAME_LEN == 0) expQ.push_back(SYNC);
`endif
        expQ.push_back(w);
        sampleIdx++;
    endtask

    task automatic waitForRts(input logic [1:0] want, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i <= budget && !seen; i++) begin
            if (RequestToSend === want) seen = 1'b1;
            else if (i < budget) tick();
        end
    endtask

    task automatic applyReset();
        Reset = 1'b1;
        SampleValid = 1'b0;
        SampleData = 16'h0000;
        ClearOverflow = 1'b0;
        DataReceived = 2'b00;
        tick();
        tick();
        Reset = 1'b0;
        expQ.delete();
        sampleIdx = 0;
    endtask

    task automatic test_reset();
        applyReset();
        checks++; if (RequestToSend !== 2'b00) begin failures++; $display("[TB] FAIL reset_rts: got %b, expected 00", RequestToSend); end
        checks++; if (Data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_data: got %h, expected 0000", Data); end
        checks++; if (Full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %b, expected 0", Full); end
        checks++; if (Overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b, expected 0", Overflow); end
        checks++; if (Count !== '0) begin failures++; $display("[TB] FAIL reset_count: got %0d, expected 0", Count); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, expected 0", Busy); end
    endtask

`ifndef TX_SAMPLE_FRAMER_HEADER_EN
    task automatic test_single_word();
        applyReset();
        SampleValid = 1'b1; SampleData = 16'h1234;
        tick();
        SampleValid = 1'b0;
        checks++; if (Count !== (AW+1)'(1) || RequestToSend !== 2'b00) begin failures++; $display("[TB] FAIL single_written: got count %0d rts %b, expected 1 00", Count, RequestToSend); end
        tick();
        checks++; if (RequestToSend !== 2'b10 || Data !== 16'h1234) begin failures++; $display("[TB] FAIL single_req_hi: got %b %h, expected 10 1234", RequestToSend, Data); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (RequestToSend !== 2'b10 || Data !== 16'h1234) begin failures++; $display("[TB] FAIL single_hold_hi: got %b %h, expected 10 1234", RequestToSend, Data); end
        end
        DataReceived = 2'b10; tick(); DataReceived = 2'b00;
        checks++; if (RequestToSend !== 2'b01 || Data !== 16'h1234) begin failures++; $display("[TB] FAIL single_req_lo: got %b %h, expected 01 1234", RequestToSend, Data); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (RequestToSend !== 2'b01 || Data !== 16'h1234) begin failures++; $display("[TB] FAIL single_hold_lo: got %b %h, expected 01 1234", RequestToSend, Data); end
        end
        DataReceived = 2'b01; tick(); DataReceived = 2'b00;
        checks++; if (RequestToSend !== 2'b00 || Busy !== 1'b0 || Data !== 16'h1234) begin failures++; $display("[TB] FAIL single_done: got rts %b busy %b data %h, expected 00 0 1234", RequestToSend, Busy, Data); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  rtsSeen[$];
        logic [15:0] dataSeen[$];
        int maxCount = 0;
        int nReq = 0;
        logic [1:0] expRts;
        applyReset();
        for (int c = 0; c < 16; c++) begin
            SampleValid = (c < 4);
            SampleData = 16'(c + 1);
            DataReceived = RequestToSend;
            tick();
            rtsSeen.push_back(RequestToSend);
            dataSeen.push_back(Data);
            if (int'(Count) > maxCount) maxCount = int'(Count);
        end
        SampleValid = 1'b0; DataReceived = 2'b00;
        for (int c = 0; c < 16; c++) begin
            if (c == 0 || c > 12) expRts = 2'b00;
            else if ((c - 1) % 3 == 0) expRts = 2'b10;
            else if ((c - 1) % 3 == 1) expRts = 2'b01;
            else expRts = 2'b00;
            if (rtsSeen[c] != 2'b00) nReq++;
            checks++; if (rtsSeen[c] !== expRts) begin failures++; $display("[TB] FAIL b2b_rts[%0d]: got %b, expected %b", c, rtsSeen[c], expRts); end
            if (expRts == 2'b10) begin
                checks++; if (dataSeen[c] !== 16'((c - 1) / 3 + 1)) begin failures++; $display("[TB] FAIL b2b_data[%0d]: got %h, expected %h", c, dataSeen[c], 16'((c - 1) / 3 + 1)); end
            end
        end
        checks++; if (nReq !== 8) begin failures++; $display("[TB] FAIL b2b_requests: got %0d, expected 8", nReq); end
        checks++; if (maxCount !== 3) begin failures++; $display("[TB] FAIL b2b_max_count: got %0d, expected 3", maxCount); end
        checks++; if (Busy !== 1'b0 || Count !== '0) begin failures++; $display("[TB] FAIL b2b_drained: got busy %b count %0d, expected 0 0", Busy, Count); end
    endtask

    task automatic test_fill_overflow();
        logic [15:0] w[DEPTH + 2];
        bit seen;
        logic [15:0] expWord;
        applyReset();
        for (int i = 0; i < DEPTH + 2; i++) w[i] = 16'($urandom);
        for (int i = 0; i < DEPTH + 2; i++) begin
            SampleValid = 1'b1; SampleData = w[i];
            tick();
            if (i == DEPTH - 1) begin
                checks++; if (Full !== 1'b0 || Count !== (AW+1)'(DEPTH - 1)) begin failures++; $display("[TB] FAIL fill_almost: got full %b count %0d, expected 0 %0d", Full, Count, DEPTH - 1); end
            end
            if (i == DEPTH) begin
                checks++; if (Full !== 1'b1 || Overflow !== 1'b0) begin failures++; $display("[TB] FAIL fill_full: got full %b ovf %b, expected 1 0", Full, Overflow); end
            end
        end
        SampleValid = 1'b0;
        checks++; if (Overflow !== 1'b1) begin failures++; $display("[TB] FAIL fill_overflow: got %b, expected 1", Overflow); end
        checks++; if (Count !== (AW+1)'(DEPTH) || Full !== 1'b1) begin failures++; $display("[TB] FAIL fill_count: got %0d full %b, expected %0d 1", Count, Full, DEPTH); end
        checks++; if (Data !== w[0] || RequestToSend !== 2'b10) begin failures++; $display("[TB] FAIL fill_head: got %h %b, expected %h 10", Data, RequestToSend, w[0]); end
        ClearOverflow = 1'b1; SampleValid = 1'b1; SampleData = 16'hDEAD;
        tick();
        SampleValid = 1'b0;
        checks++; if (Overflow !== 1'b1 || Count !== (AW+1)'(DEPTH)) begin failures++; $display("[TB] FAIL ovf_set_wins: got ovf %b count %0d, expected 1 %0d", Overflow, Count, DEPTH); end
        tick();
        ClearOverflow = 1'b0;
        checks++; if (Overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear: got %b, expected 0", Overflow); end
        for (int i = 0; i <= DEPTH; i++) expQ.push_back(w[i]);
        while (expQ.size() > 0) begin
            expWord = expQ.pop_front();
            waitForRts(2'b10, 20, seen);
            checks++; if (!seen || Data !== expWord) begin failures++; $display("[TB] FAIL drain_word: got %h seen %b, expected %h", Data, seen, expWord); expQ.delete(); end
            DataReceived = 2'b10; tick(); DataReceived = 2'b01; tick(); DataReceived = 2'b00;
        end
        tick();
        checks++; if (Busy !== 1'b0 || Count !== '0) begin failures++; $display("[TB] FAIL drain_done: got busy %b count %0d, expected 0 0", Busy, Count); end
    endtask

    task automatic test_wrong_acks();
        applyReset();
        SampleValid = 1'b1; SampleData = 16'hBEEF;
        tick();
        SampleValid = 1'b0;
        tick();
        DataReceived = 2'b01; tick(); DataReceived = 2'b00;
        checks++; if (RequestToSend !== 2'b10 || Data !== 16'hBEEF) begin failures++; $display("[TB] FAIL stray_lo_in_hi: got %b %h, expected 10 beef", RequestToSend, Data); end
        tick();
        DataReceived = 2'b10; tick(); DataReceived = 2'b00;
        checks++; if (RequestToSend !== 2'b01) begin failures++; $display("[TB] FAIL ack_hi: got %b, expected 01", RequestToSend); end
        DataReceived = 2'b10; tick(); DataReceived = 2'b00;
        checks++; if (RequestToSend !== 2'b01) begin failures++; $display("[TB] FAIL stray_hi_in_lo: got %b, expected 01", RequestToSend); end
        DataReceived = 2'b11; tick(); DataReceived = 2'b00;
        checks++; if (RequestToSend !== 2'b00 || Busy !== 1'b0) begin failures++; $display("[TB] FAIL ack_both_lo: got %b busy %b, expected 00 0", RequestToSend, Busy); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] nw;
        applyReset();
        for (int i = 0; i < 3; i++) begin
            SampleValid = 1'b1; SampleData = 16'($urandom);
            tick();
        end
        SampleValid = 1'b0;
        DataReceived = 2'b10; tick(); DataReceived = 2'b00;
        checks++; if (RequestToSend !== 2'b01) begin failures++; $display("[TB] FAIL mid_in_lo: got %b, expected 01", RequestToSend); end
        Reset = 1'b1; tick(); Reset = 1'b0;
        checks++; if (RequestToSend !== 2'b00 || Count !== '0 || Data !== 16'h0000 || Busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset: got rts %b count %0d data %h busy %b, expected 00 0 0000 0", RequestToSend, Count, Data, Busy); end
        nw = 16'($urandom);
        SampleValid = 1'b1; SampleData = nw; tick(); SampleValid = 1'b0;
        tick();
        checks++; if (RequestToSend !== 2'b10 || Data !== nw) begin failures++; $display("[TB] FAIL mid_restart: got %b %h, expected 10 %h", RequestToSend, Data, nw); end
        DataReceived = 2'b11; tick(); tick(); DataReceived = 2'b00;
        checks++; if (RequestToSend !== 2'b00 || Count !== '0) begin failures++; $display("[TB] FAIL mid_finish: got %b count %0d, expected 00 0", RequestToSend, Count); end
    endtask
`endif

`ifdef TX_SAMPLE_FRAMER_HEADER_EN
    task automatic test_header();
        logic [15:0] s[4];
        logic [15:0] expWords[6];
        bit seen;
        applyReset();
        for (int i = 0; i < 4; i++) s[i] = 16'($urandom);
        expWords[0] = SYNC; expWords[1] = s[0]; expWords[2] = s[1];
        expWords[3] = SYNC; expWords[4] = s[2]; expWords[5] = s[3];
        for (int i = 0; i < 4; i++) begin
            SampleValid = 1'b1; SampleData = s[i]; tick();
        end
        SampleValid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            waitForRts(2'b10, 20, seen);
            checks++; if (!seen || Data !== expWords[k]) begin failures++; $display("[TB] FAIL header_word[%0d]: got %h seen %b, expected %h", k, Data, seen, expWords[k]); end
            DataReceived = 2'b10; tick(); DataReceived = 2'b01; tick(); DataReceived = 2'b00;
        end
        tick();
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL header_done: got busy %b, expected 0", Busy); end
    endtask
`endif

    task automatic test_random();
        localparam int K = 12;
        int nWords;
        bit abort = 1'b0;
        applyReset();
`ifdef TX_SAMPLE_FRAMER_HEADER_EN
        nWords = K + (K + FRAME_LEN - 1) / FRAME_LEN;
`else
        nWords = K;
`endif
        fork
            begin
                for (int k = 0; k < K; k++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    SampleValid = 1'b1;
                    SampleData = 16'($urandom);
                    pushSample(SampleData);
                    tick();
                    SampleValid = 1'b0;
                end
            end
            begin
                bit seen;
                logic [15:0] expWord;
                for (int n = 0; n < nWords && !abort; n++) begin
                    waitForRts(2'b10, 200, seen);
                    checks++; if (!seen || expQ.size() == 0) begin failures++; $display("[TB] FAIL rand_request[%0d]: got seen %b queued %0d, expected 1 and >0", n, seen, expQ.size()); abort = 1'b1; end
                    if (!abort) begin
                        expWord = expQ.pop_front();
                        checks++; if (Data !== expWord) begin failures++; $display("[TB] FAIL rand_data[%0d]: got %h, expected %h", n, Data, expWord); end
                        if ($urandom_range(0, 1) == 1) begin
                            DataReceived = 2'b01; tick(); DataReceived = 2'b00;
                        end
                        repeat ($urandom_range(0, 3)) tick();
                        checks++; if (RequestToSend !== 2'b10 || Data !== expWord) begin failures++; $display("[TB] FAIL rand_hold_hi[%0d]: got %b %h, expected 10 %h", n, RequestToSend, Data, expWord); end
                        DataReceived = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
                        tick();
                        DataReceived = 2'b00;
                        checks++; if (RequestToSend !== 2'b01 || Data !== expWord) begin failures++; $display("[TB] FAIL rand_lo[%0d]: got %b %h, expected 01 %h", n, RequestToSend, Data, expWord); end
                        repeat ($urandom_range(0, 3)) tick();
                        DataReceived = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
                        tick();
                        DataReceived = 2'b00;
                        checks++; if (RequestToSend !== 2'b00) begin failures++; $display("[TB] FAIL rand_done[%0d]: got %b, expected 00", n, RequestToSend); end
                    end
                end
            end
        join
        tick();
        checks++; if (expQ.size() != 0 || Busy !== 1'b0) begin failures++; $display("[TB] FAIL rand_drained: got queued %0d busy %b, expected 0 0", expQ.size(), Busy); end
    endtask

    initial begin
        test_reset();
`ifdef TX_SAMPLE_FRAMER_HEADER_EN
        test_header();
`else
        test_single_word();
        test_back_to_back();
        test_fill_overflow();
        test_wrong_acks();
        test_reset_mid();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
